// File: rtl/rtc_bus_pkg.sv
// Shared RTC bus definitions (register map, commands, FSM encoding) for the reader and writer.
// Defining RTC_READER_TIMER_EN adds the timer registers 0x41..0x43 to the read list.
package rtc_bus_pkg;

  localparam int PHASE_CYC_DEF = 7;

  localparam logic [7:0] ADDR_SEG   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HORA  = 8'h23;
  localparam logic [7:0] ADDR_FECHA = 8'h24;
  localparam logic [7:0] ADDR_MES   = 8'h25;
  localparam logic [7:0] ADDR_ANIO  = 8'h26;
  localparam logic [7:0] ADDR_TSEG  = 8'h41;
  localparam logic [7:0] ADDR_TMIN  = 8'h42;
  localparam logic [7:0] ADDR_THORA = 8'h43;
  localparam logic [7:0] CMD_LATCH  = 8'hF0;
  localparam logic [7:0] CMD_F1     = 8'hF1;
  localparam logic [7:0] CMD_F2     = 8'hF2;

`ifdef RTC_READER_TIMER_EN
  localparam int NUM_REGS = 9;
`else
  localparam int NUM_REGS = 6;
`endif
  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD_REGS,
    ST_UPDATE
  } rdState_t;

  // Maps a position in the read burst to its RTC register address.
  function automatic logic [7:0] regAddr(input logic [IDX_W-1:0] idx);
    logic [7:0] a;
    case (idx)
      IDX_W'(0): a = ADDR_SEG;
      IDX_W'(1): a = ADDR_MIN;
      IDX_W'(2): a = ADDR_HORA;
      IDX_W'(3): a = ADDR_FECHA;
      IDX_W'(4): a = ADDR_MES;
      IDX_W'(5): a = ADDR_ANIO;
`ifdef RTC_READER_TIMER_EN
      IDX_W'(6): a = ADDR_TSEG;
      IDX_W'(7): a = ADDR_TMIN;
      IDX_W'(8): a = ADDR_THORA;
`endif
      default:   a = ADDR_SEG;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/rtc_bus_cycle.sv
// One RTC bus access (address window, gap, data window, gap) of PHASE_CYC cycles each.
// A new go may be accepted on the ack cycle so accesses run back-to-back.
module rtc_bus_cycle
  import rtc_bus_pkg::*;
#(
  parameter int PHASE_CYC = PHASE_CYC_DEF,
  parameter int CNT_W     = 5
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       i_go,
  input  logic       i_rnw,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  input  logic [7:0] i_dat,
  output logic [7:0] o_rdata,
  output logic       o_ack,
  output logic [7:0] o_addrDat,
  output logic       o_busOe,
  output logic       o_ad,
  output logic       o_rd,
  output logic       o_wr,
  output logic       o_cs
);

  logic             r_active;
  logic [1:0]       r_win;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rnw;
  logic [7:0]       r_addr;
  logic [7:0]       r_wdata;
  logic [7:0]       r_rdata;
  logic             w_lastCyc;

  assign w_lastCyc = (r_cnt == CNT_W'(PHASE_CYC - 1));
  assign o_ack     = r_active && (r_win == 2'd3) && w_lastCyc;
  assign o_rdata   = r_rdata;

  always_ff @(posedge clk_i) begin
    if (!reset) begin
      r_active <= 1'b0;
      r_win    <= 2'd0;
      r_cnt    <= '0;
      r_rnw    <= 1'b0;
      r_addr   <= 8'h00;
      r_wdata  <= 8'h00;
      r_rdata  <= 8'h00;
    end else begin
      if (i_go && (!r_active || o_ack)) begin
        r_active <= 1'b1;
        r_win    <= 2'd0;
        r_cnt    <= '0;
        r_rnw    <= i_rnw;
        r_addr   <= i_addr;
        r_wdata  <= i_wdata;
      end else if (r_active) begin
        if (w_lastCyc) begin
          r_cnt <= '0;
          r_win <= r_win + 2'd1;
          if (r_win == 2'd3) r_active <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      // Capture at the very end of the read window, when the RTC output has settled longest.
      if (r_active && r_rnw && (r_win == 2'd2) && w_lastCyc) r_rdata <= i_dat;
    end
  end

  always_comb begin
    o_cs      = 1'b1;
    o_wr      = 1'b1;
    o_rd      = 1'b1;
    o_ad      = 1'b1;
    o_busOe   = 1'b0;
    o_addrDat = 8'h00;
    if (r_active) begin
      case (r_win)
        2'd0: begin
          o_ad      = 1'b0;
          o_cs      = 1'b0;
          o_wr      = 1'b0;
          o_busOe   = 1'b1;
          o_addrDat = r_addr;
        end
        2'd1: begin
          o_ad      = 1'b0;
          o_busOe   = 1'b1;
          o_addrDat = r_addr;
        end
        2'd2: begin
          o_cs = 1'b0;
          if (r_rnw) begin
            o_rd = 1'b0;
          end else begin
            o_wr      = 1'b0;
            o_busOe   = 1'b1;
            o_addrDat = r_wdata;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/rtc_bus_reader.sv
// Reads the RTC time/date: buffer-latch command 0xF0, then registers 0x21..0x26 into stable outputs.
// Defining RTC_READER_TIMER_EN also reads 0x41..0x43 into t_seg/t_min/t_hora.
module rtc_bus_reader
  import rtc_bus_pkg::*;
#(
  parameter int PHASE_CYC = PHASE_CYC_DEF,
  parameter int CNT_W     = 5
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] dat_i,
  output logic [7:0] addr_dat_o,
  output logic       bus_oe,
  output logic       AD_o,
  output logic       RD,
  output logic       WR,
  output logic       CS,
  output logic       busy,
  output logic       done,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] fecha,
  output logic [7:0] mes,
  output logic [7:0] anio
`ifdef RTC_READER_TIMER_EN
  ,
  output logic [7:0] t_seg,
  output logic [7:0] t_min,
  output logic [7:0] t_hora
`endif
);

  rdState_t         r_state;
  rdState_t         w_nextState;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_nextIdx;
  logic [7:0]       r_shadow [NUM_REGS];
  logic             w_go;
  logic             w_rnw;
  logic             w_ack;
  logic             w_lastIdx;
  logic [7:0]       w_addr;
  logic [7:0]       w_wdata;
  logic [7:0]       w_rdata;

  assign w_lastIdx = (r_idx == IDX_W'(NUM_REGS - 1));
  // The request lines describe the access that starts on the next go, not the current one.
  assign w_nextIdx = (r_state == ST_RD_REGS) ? r_idx + 1'b1 : '0;

  always_ff @(posedge clk_i) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_nextState = ST_CMD;
      ST_CMD:     if (w_ack) w_nextState = ST_RD_REGS;
      ST_RD_REGS: if (w_ack && w_lastIdx) w_nextState = ST_UPDATE;
      ST_UPDATE:  w_nextState = ST_IDLE;
      default:    w_nextState = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    w_go    = 1'b0;
    w_rnw   = 1'b1;
    w_addr  = regAddr(w_nextIdx);
    w_wdata = 8'h00;
    case (r_state)
      ST_IDLE: begin
        w_go    = start;
        w_rnw   = 1'b0;
        w_addr  = CMD_LATCH;
        w_wdata = CMD_LATCH;
      end
      ST_CMD: begin
        busy = 1'b1;
        w_go = w_ack;
      end
      ST_RD_REGS: begin
        busy = 1'b1;
        w_go = w_ack && !w_lastIdx;
      end
      ST_UPDATE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset) begin
      r_idx <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_shadow[i] <= 8'h00;
      seg   <= 8'h00;
      min   <= 8'h00;
      hora  <= 8'h00;
      fecha <= 8'h00;
      mes   <= 8'h00;
      anio  <= 8'h00;
`ifdef RTC_READER_TIMER_EN
      t_seg  <= 8'h00;
      t_min  <= 8'h00;
      t_hora <= 8'h00;
`endif
    end else begin
      if (r_state == ST_CMD) begin
        r_idx <= '0;
      end else if ((r_state == ST_RD_REGS) && w_ack) begin
        r_shadow[r_idx] <= w_rdata;
        if (!w_lastIdx) r_idx <= r_idx + 1'b1;
      end
      // All outputs switch on the same edge so a consumer never sees a mixed old/new set.
      if (r_state == ST_UPDATE) begin
        seg   <= r_shadow[0];
        min   <= r_shadow[1];
        hora  <= r_shadow[2];
        fecha <= r_shadow[3];
        mes   <= r_shadow[4];
        anio  <= r_shadow[5];
`ifdef RTC_READER_TIMER_EN
        t_seg  <= r_shadow[6];
        t_min  <= r_shadow[7];
        t_hora <= r_shadow[8];
`endif
      end
    end
  end

  rtc_bus_cycle #(
    .PHASE_CYC (PHASE_CYC),
    .CNT_W     (CNT_W)
  ) u_cycle (
    .clk_i     (clk_i),
    .reset     (reset),
    .i_go      (w_go),
    .i_rnw     (w_rnw),
    .i_addr    (w_addr),
    .i_wdata   (w_wdata),
    .i_dat     (dat_i),
    .o_rdata   (w_rdata),
    .o_ack     (w_ack),
    .o_addrDat (addr_dat_o),
    .o_busOe   (bus_oe),
    .o_ad      (AD_o),
    .o_rd      (RD),
    .o_wr      (WR),
    .o_cs      (CS)
  );

endmodule

// File: tb/tb_rtc_bus_reader.sv
// Scoreboard bench for rtc_bus_reader: RTC register model, expected bursts queued at start, monitor checks on done.
// Build with RTC_READER_TIMER_EN defined to cover the timer registers.
module tb_rtc_bus_reader;

  localparam int PH  = 7;
  localparam int ACC = 4 * PH;
`ifdef RTC_READER_TIMER_EN
  localparam int NREG = 9;
`else
  localparam int NREG = 6;
`endif
  localparam int LAT = 1 + (NREG + 1) * ACC;

  typedef struct packed {
    int              doneCyc;
    logic [8:0][7:0] vals;
  } expEntry_t;

  logic clk, reset, start;
  logic [7:0] datI, addrDat;
  logic busOe, adO, rd, wr, cs, busy, done;
  logic [7:0] seg, min, hora, fecha, mes, anio;
`ifdef RTC_READER_TIMER_EN
  logic [7:0] tSeg, tMin, tHora;
`endif

  int checks, failures, cyc, freeCyc, lastStart, strobeBad, idleBad;
  int rdLowRun, csDataRun;
  bit monBusy;
  logic prevRd, prevWr, prevCs;
  logic [7:0] rtcMem [256];
  logic [7:0] rtcLatch;
  logic [7:0] readLog[$];
  logic [15:0] writeLog[$];
  expEntry_t expQ[$];
  expEntry_t monEntry;
  logic [7:0] planVals [9];

  rtc_bus_reader #(.PHASE_CYC(PH), .CNT_W(5)) dut (
    .clk_i(clk), .reset(reset), .start(start), .dat_i(datI),
    .addr_dat_o(addrDat), .bus_oe(busOe), .AD_o(adO), .RD(rd), .WR(wr), .CS(cs),
    .busy(busy), .done(done),
    .seg(seg), .min(min), .hora(hora), .fecha(fecha), .mes(mes), .anio(anio)
`ifdef RTC_READER_TIMER_EN
    , .t_seg(tSeg), .t_min(tMin), .t_hora(tHora)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign datI = rtcMem[rtcLatch];

  function automatic logic [7:0] addrOf(input int i);
    if (i < 6) return 8'(8'h21 + i);
    return 8'(8'h41 + i - 6);
  endfunction

  function automatic logic [7:0] actualOut(input int i);
    case (i)
      0: return seg;
      1: return min;
      2: return hora;
      3: return fecha;
      4: return mes;
      5: return anio;
`ifdef RTC_READER_TIMER_EN
      6: return tSeg;
      7: return tMin;
      8: return tHora;
`endif
      default: return 8'h00;
    endcase
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Pulses start for one cycle; the model accepts it only once the previous burst's UPDATE cycle is over.
  task automatic applyStimulus(input bit randomVals);
    expEntry_t entry;
    int s;
    s = cyc;
    start = 1'b1;
    if (s >= freeCyc) begin
      if (randomVals)
        for (int i = 0; i < NREG; i++) rtcMem[addrOf(i)] = 8'($urandom);
      entry = '0;
      entry.doneCyc = s + LAT;
      for (int i = 0; i < NREG; i++) entry.vals[i] = rtcMem[addrOf(i)];
      expQ.push_back(entry);
      freeCyc = s + LAT + 1;
      lastStart = s;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((expQ.size() > 0 || monBusy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_pending", expQ.size(), 0);
    @(negedge clk);
  endtask

  // RTC model: latch address in the address window, serve reads, log accesses and strobe widths.
  always @(negedge clk) begin
    if (reset !== 1'b1) begin
      prevRd = 1'b1;
      prevWr = 1'b1;
      prevCs = 1'b1;
      rdLowRun = 0;
      csDataRun = 0;
    end else begin
      if (cs === 1'b0 && wr === 1'b0 && adO === 1'b0) rtcLatch = addrDat;
      if (rd === 1'b0) begin
        rdLowRun++;
        if (busOe !== 1'b0 || cs !== 1'b0) strobeBad++;
      end
      if (cs === 1'b0 && adO === 1'b1) csDataRun++;
      if (rd === 1'b1 && prevRd === 1'b0) checkOutput("rd_low_cycles", rdLowRun, PH);
      if (rd === 1'b1) rdLowRun = 0;
      if (cs === 1'b1 && prevCs === 1'b0 && csDataRun > 0) checkOutput("cs_data_cycles", csDataRun, PH);
      if (cs === 1'b1) csDataRun = 0;
      if (rd === 1'b0 && prevRd === 1'b1) readLog.push_back(rtcLatch);
      if (wr === 1'b0 && prevWr === 1'b1 && adO === 1'b1) writeLog.push_back({rtcLatch, addrDat});
      prevRd = rd;
      prevWr = wr;
      prevCs = cs;
    end
  end

  // Monitor: every done pulse must match the oldest queued burst.
  always @(negedge clk) begin
    if (reset === 1'b1 && done === 1'b1) begin
      monBusy = 1'b1;
      checkOutput("done_expected", int'(expQ.size() > 0), 1);
      if (expQ.size() > 0) begin
        monEntry = expQ.pop_front();
        checkOutput("done_cycle", cyc, monEntry.doneCyc);
        checkOutput("read_count", readLog.size(), NREG);
        for (int i = 0; i < NREG && i < readLog.size(); i++)
          checkOutput($sformatf("read_addr%0d", i), int'(readLog[i]), int'(addrOf(i)));
        checkOutput("write_count", writeLog.size(), 1);
        if (writeLog.size() > 0) checkOutput("latch_cmd", int'(writeLog[0]), 'hF0F0);
        readLog.delete();
        writeLog.delete();
        @(negedge clk);
        checkOutput("done_width", int'(done), 0);
        checkOutput("busy_after_done", int'(busy), 0);
        for (int i = 0; i < NREG; i++)
          checkOutput($sformatf("out_reg%0d", i), int'(actualOut(i)), int'(monEntry.vals[i]));
      end
      monBusy = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; checks = 0; failures = 0; cyc = 0;
    freeCyc = 0; lastStart = 0; strobeBad = 0; idleBad = 0; monBusy = 1'b0;
    rtcLatch = 8'h00;
    for (int i = 0; i < 256; i++) rtcMem[i] = 8'($urandom);
    planVals = '{8'h45, 8'h30, 8'h13, 8'h26, 8'h04, 8'h16, 8'h59, 8'h58, 8'h23};

    repeat (3) @(negedge clk);
    checkOutput("rst_rd", int'(rd), 1);
    checkOutput("rst_wr", int'(wr), 1);
    checkOutput("rst_cs", int'(cs), 1);
    checkOutput("rst_ad", int'(adO), 1);
    checkOutput("rst_oe", int'(busOe), 0);
    checkOutput("rst_addr_dat", int'(addrDat), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    for (int i = 0; i < NREG; i++) checkOutput($sformatf("rst_out%0d", i), int'(actualOut(i)), 0);
    reset = 1'b1;

    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rd !== 1'b1 || wr !== 1'b1 || cs !== 1'b1 || busOe !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
        idleBad++;
      for (int i = 0; i < NREG; i++) if (actualOut(i) !== 8'h00) idleBad++;
    end
    checkOutput("idle_hold", idleBad, 0);

    $display("[TB] directed burst with a start while busy");
    for (int i = 0; i < NREG; i++) rtcMem[addrOf(i)] = planVals[i];
    applyStimulus(1'b0);
    waitCycle(lastStart + 50);
    applyStimulus(1'b1);
    drain();

    $display("[TB] start during UPDATE, then right after");
    applyStimulus(1'b1);
    waitCycle(lastStart + LAT);
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    drain();

    $display("[TB] random start pulses");
    for (int k = 0; k < 6; k++) begin
      repeat ($urandom_range(0, 250)) @(negedge clk);
      applyStimulus(1'b1);
    end
    drain();

    $display("[TB] reset in the middle of a burst");
    applyStimulus(1'b1);
    waitCycle(lastStart + 90);
    reset = 1'b0;
    expQ.delete();
    @(negedge clk);
    readLog.delete();
    writeLog.delete();
    checkOutput("abort_rd", int'(rd), 1);
    checkOutput("abort_wr", int'(wr), 1);
    checkOutput("abort_cs", int'(cs), 1);
    checkOutput("abort_oe", int'(busOe), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    for (int i = 0; i < NREG; i++) checkOutput($sformatf("abort_out%0d", i), int'(actualOut(i)), 0);
    reset = 1'b1;
    freeCyc = 0;
    repeat (300) @(negedge clk);

    applyStimulus(1'b1);
    drain();

    checkOutput("strobe_contention", strobeBad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rtc_bus_reader.md
Name: rtc_bus_reader

Overview:
- Reads current time/date from the external RTC over the multiplexed address/data bus (AD, RD, WR, CS, all strobes active-low).
- Opposite direction of the RTC initialization writer: the writer programs the RTC; this block reads it back.
- On a start pulse it issues the buffer-transfer command (0xF0), then reads the seconds..year registers.
- Presents results as stable BCD bytes to the display/control logic. Shares the bus with the writer; the top-level arbiter mux selects one owner.

Parameters:
- PHASE_CYC, 7: clock cycles per strobe-active window and per idle gap; must be >= 2.
- CNT_W, 5: width of the phase counter; must satisfy 2^CNT_W > PHASE_CYC.

Ports:
- clk_i, input, 1: single system clock, rising edge.
- reset, input, 1: synchronous, active-low reset.
- start, input, 1: one-cycle request to begin a read burst; ignored while busy=1.
- dat_i, input, 8: bus value returned by the RTC during read data phase.
- addr_dat_o, output, 8: address or write data driven to the bus.
- bus_oe, output, 1: 1 = drive addr_dat_o onto the bus; 0 = release to high-Z (the top level owns the tristate buffer).
- AD_o, output, 1: 0 = address phase, 1 = data phase.
- RD, output, 1: read strobe, active-low.
- WR, output, 1: write strobe, active-low.
- CS, output, 1: chip select, active-low.
- busy, output, 1: burst in progress.
- done, output, 1: one-cycle pulse when the burst completes and the outputs are updated.
- seg, min, hora, fecha, mes, anio, output, 8 each: BCD registers 0x21..0x26.

Behaviour:
- Reset (reset=0 at a clock edge):
  - RD=1, WR=1, CS=1, AD_o=1, bus_oe=0, addr_dat_o=0x00.
  - busy=0, done=0, all data outputs 0x00, FSM goes to IDLE, counters cleared.
  - Reset mid-burst aborts immediately with the same values; the RTC sees CS high on the next cycle.
- Access: four windows of PHASE_CYC cycles each (4*PHASE_CYC = 28 cycles by default).
  - Window 1, address: AD_o=0, CS=0, WR=0, RD=1, bus_oe=1, addr_dat_o=register address.
  - Window 2, gap: CS=WR=RD=1, bus_oe stays 1, address held.
  - Window 3, data, write access: AD_o=1, CS=0, WR=0, RD=1, bus_oe=1, addr_dat_o=data.
  - Window 3, data, read access: AD_o=1, CS=0, RD=0, WR=1, bus_oe=0. dat_i is sampled into a shadow register on the last cycle of the window.
  - Window 4, gap: all strobes high, bus_oe=0, AD_o=1.
- FSM states: IDLE -> CMD -> RD_REGS -> UPDATE -> IDLE.
  - IDLE: busy=0. start=1 moves to CMD; busy=1 from the next cycle.
  - CMD: one write access, address 0xF0, data 0xF0 (latches time into the RTC buffer).
  - RD_REGS: read accesses to 0x21, 0x22, 0x23, 0x24, 0x25, 0x26 in order, back-to-back, with a 3-bit index. Advance after the last gap cycle of each access.
  - UPDATE: one cycle. All shadow bytes copy to the outputs simultaneously; done=1 for that cycle only; busy=0 on the following cycle.
- Outputs never change mid-burst. A consumer sees either the full old set or the full new set.
- Latency with defaults: start at cycle 0 -> done at cycle 1 + 7*28 = 197.
- start asserted in the same cycle as done/UPDATE is ignored. start is accepted only in IDLE.
- No data validation: BCD bytes are passed through unchanged.

Optional Feature:
- Macro RTC_READER_TIMER_EN.
- When defined:
  - Extra outputs t_seg, t_min, t_hora (8 bits each).
  - After 0x26 the block also reads 0x41, 0x42, 0x43; the index widens to cover 9 registers.
  - Latency becomes 1 + 10*28 = 281 cycles.
  - The extra outputs update in UPDATE together with the others; reset value 0x00.
- When undefined: these ports and their logic are absent, and the burst is exactly as above.

Decomposition:
- Shared package rtc_bus_pkg holds:
  - Register address constants (ADDR_SEG=0x21 .. ADDR_ANIO=0x26, ADDR_TSEG=0x41 .. ADDR_THORA=0x43, CMD_LATCH=0xF0, CMD_F1, CMD_F2).
  - FSM state encoding.
  - Default PHASE_CYC.
- The writer also uses this package.
- One sub-module, rtc_bus_cycle:
  - Executes a single read or write access.
  - Inputs: go, rnw, addr, wdata.
  - Outputs: rdata, ack, plus bus/strobe pins.
  - Owns the phase counter.
- The top FSM only sequences addresses and shadows.

Test Plan:
- Reset then idle: reset=0 for 3 cycles, then 1 -> RD=WR=CS=1, bus_oe=0, busy=0, all outputs 0x00 held for 100 cycles.
- Full burst: RTC model returns 0x45, 0x30, 0x13, 0x26, 0x04, 0x16 -> first access addr 0xF0 with WR pulse; done at cycle 197; outputs seg=0x45, min=0x30, hora=0x13, fecha=0x26, mes=0x04, anio=0x16.
- Strobe timing: check CS/RD low for exactly 7 cycles per data phase, and bus_oe=0 whenever RD=0 -> no bus contention cycles.
- start while busy: pulse start at cycle 50 -> ignored; exactly one done; second start after done -> a fresh burst with new model values.
- Reset mid-burst: reset=0 at cycle 90 -> next cycle all strobes high, bus_oe=0, outputs 0x00, no done pulse.
- RTC_READER_TIMER_EN defined, model returns 0x59, 0x58, 0x23 for 0x41..0x43 -> t_seg=0x59, t_min=0x58, t_hora=0x23; done at cycle 281.
